mips32_mem_arbiter: RTL and testbench
=====================================

// Module: mips32_mem_arbiter
// PURPOSE
//   Arbitrates one single-port synchronous memory (Mem) between three requesters:
//   the mips32 instruction fetch (IF), the MEM-stage data access for LW/SW (DM),
//   and an external program loader/debug port (LD).
//   - Sits between the mips32 pipeline and the memory array.
//   - Issues a stall to IF when it loses arbitration, and an anti-starvation boost
//     guarantees IF progress.
// PARAMETERS
//   AW           10  word-address width
//   DW           32  data width
//   STARVE_LIMIT 4   consecutive IF denials before IF gets top priority (>=1)
// PORTS
//   clock        in   1   system clock, rising edge
//   reset        in   1   asynchronous, active-high
//   if_req       in   1   IF read request
//   if_addr      in   AW  IF word address
//   if_gnt       out  1   IF granted this cycle (combinational)
//   if_rvalid    out  1   IF read data valid
//   dm_req       in   1   DM request
//   dm_we        in   1   DM write enable (SW)
//   dm_addr      in   AW  DM word address
//   dm_wdata     in   DW  DM write data
//   dm_gnt       out  1   DM granted this cycle
//   dm_rvalid    out  1   DM read data valid (LW only)
//   ld_req       in   1   loader request
//   ld_we        in   1   loader write enable
//   ld_addr      in   AW  loader word address
//   ld_wdata     in   DW  loader write data
//   ld_gnt       out  1   loader granted this cycle
//   ld_rvalid    out  1   loader read data valid
//   rdata        out  DW  shared read data, qualified by *_rvalid
//   if_stall     out  1   if_req & ~if_gnt
//   mem_en       out  1   memory enable
//   mem_we       out  1   memory write enable
//   mem_addr     out  AW  memory address
//   mem_wdata    out  DW  memory write data
//   mem_rdata    in   DW  memory read data, 1 cycle after mem_en & ~mem_we
// BEHAVIOUR
//   - Reset:
//     - All *_rvalid=0, starve_cnt=0, boost=0.
//     - While reset is high, all *_gnt=0, mem_en=0 and mem_we=0.
//   - Arbitration: combinational, at most one grant per cycle.
//     - Normal priority is LD > DM > IF.
//     - When boost=1, priority is IF > LD > DM.
//   - Memory drive:
//     - mem_en = any grant.
//     - mem_we/mem_addr/mem_wdata come from the winner.
//     - An IF grant always drives mem_we=0.
//     - With no grant: mem_en=0 and mem_we=0.
//   - Response: registered.
//     - The winner's *_rvalid goes high exactly one cycle after a read grant.
//     - rdata = mem_rdata in that cycle.
//     - Writes produce no rvalid.
//     - Back-to-back grants produce back-to-back rvalids, with no bubble.
//   - Anti-starvation:
//     - Each cycle with if_req & ~if_gnt: starve_cnt += 1, saturating at STARVE_LIMIT.
//     - An IF grant, or if_req=0, clears starve_cnt and boost.
//     - boost = (starve_cnt == STARVE_LIMIT), registered.
//   - Requesters must hold req/addr/wdata stable until granted.
//     - Dropping req before grant is legal; the request is simply withdrawn.
//   - Simultaneous DM write and LD write to the same address:
//     - The higher-priority requester writes this cycle; the other writes when later granted.
//     - Last granted wins.
//   - Reset mid-operation:
//     - Pending rvalid is cancelled and the counter is cleared.
//     - A read granted in the reset-release cycle is not possible (no grants in reset).
// TESTING
//   1. Reset held, all req=1 -> all gnt=0, mem_en=0; release -> ld_gnt=1 first cycle.
//   2. Loader writes 32'h04010005 @0, 32'hFC000000 @3, then reads @0
//      -> ld_rvalid=1 next cycle, rdata=32'h04010005.
//   3. dm_req & if_req same cycle, dm_we=1 addr 120 data 5 -> dm_gnt=1, if_stall=1;
//      next cycle IF granted; DM LW @120 -> rdata=5.
//   4. dm_req held 8 cycles with if_req, STARVE_LIMIT=4 -> IF denied 4 cycles,
//      granted in 5th, starve_cnt back to 0.
//   5. IF reads @0,@1,@2 back-to-back, no other req
//      -> if_rvalid=1 three consecutive cycles, data in order.
//   6. Reset asserted in the cycle after a DM read grant
//      -> dm_rvalid stays 0; no spurious write occurs (mem_we=0).

Source files
------------

// File: rtl/mips32_mem_arbiter_if.sv
// Bus between the three requesters (IF, DM, LD), the shared memory and the arbiter.
// The master modport is the requester/memory side and the slave modport is the arbiter.
interface mips32_mem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;

  logic          ld_req;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_gnt;
  logic          ld_rvalid;

  logic [DW-1:0] rdata;
  logic          if_stall;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output ld_req, ld_we, ld_addr, ld_wdata,
    output mem_rdata,
    input  if_gnt, if_rvalid, dm_gnt, dm_rvalid, ld_gnt, ld_rvalid,
    input  rdata, if_stall, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    input  mem_rdata,
    output if_gnt, if_rvalid, dm_gnt, dm_rvalid, ld_gnt, ld_rvalid,
    output rdata, if_stall, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mips32_mem_arbiter.sv
// Single-port memory arbiter for IF / DM / loader with an IF anti-starvation boost.
// Grants are combinational; read responses arrive one cycle after the grant.
module mips32_mem_arbiter #(
  parameter int AW           = 10,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  mips32_mem_arbiter_if.slave  bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic          if_gnt, dm_gnt, ld_gnt;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  logic          if_rvalid_q, if_rvalid_d;
  logic          dm_rvalid_q, dm_rvalid_d;
  logic          ld_rvalid_q, ld_rvalid_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          boost_q, boost_d;

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    ld_gnt = 1'b0;
    // Grants are suppressed while reset is held so no access leaks out mid-reset.
    if (!reset) begin
      if (boost_q && bus.if_req) if_gnt = 1'b1;
      else if (bus.ld_req)       ld_gnt = 1'b1;
      else if (bus.dm_req)       dm_gnt = 1'b1;
      else if (bus.if_req)       if_gnt = 1'b1;
    end
  end

  always_comb begin
    mem_en    = if_gnt | dm_gnt | ld_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ld_gnt) begin
      mem_we    = bus.ld_we;
      mem_addr  = bus.ld_addr;
      mem_wdata = bus.ld_wdata;
    end else if (dm_gnt) begin
      mem_we    = bus.dm_we;
      mem_addr  = bus.dm_addr;
      mem_wdata = bus.dm_wdata;
    end else if (if_gnt) begin
      mem_addr  = bus.if_addr;
    end
  end

  always_comb begin
    if_rvalid_d  = if_gnt;
    dm_rvalid_d  = dm_gnt & ~bus.dm_we;
    ld_rvalid_d  = ld_gnt & ~bus.ld_we;
    starve_cnt_d = '0;
    if (bus.if_req && !if_gnt) begin
      starve_cnt_d = (starve_cnt_q == CW'(STARVE_LIMIT)) ? starve_cnt_q
                                                         : starve_cnt_q + CW'(1);
    end
    // Boost tracks the updated count, so IF wins on the cycle after its last denial.
    boost_d = (starve_cnt_d == CW'(STARVE_LIMIT));
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      if_rvalid_q  <= 1'b0;
      dm_rvalid_q  <= 1'b0;
      ld_rvalid_q  <= 1'b0;
      starve_cnt_q <= '0;
      boost_q      <= 1'b0;
    end else begin
      if_rvalid_q  <= if_rvalid_d;
      dm_rvalid_q  <= dm_rvalid_d;
      ld_rvalid_q  <= ld_rvalid_d;
      starve_cnt_q <= starve_cnt_d;
      boost_q      <= boost_d;
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.dm_gnt    = dm_gnt;
  assign bus.ld_gnt    = ld_gnt;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.dm_rvalid = dm_rvalid_q;
  assign bus.ld_rvalid = ld_rvalid_q;
  assign bus.rdata     = bus.mem_rdata;
  assign bus.if_stall  = bus.if_req & ~if_gnt;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Bench for mips32_mem_arbiter: directed vectors drive the requesters, expected read
// responses go into a scoreboard queue that a negedge monitor pops on every rvalid.
module tb_mips32_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  typedef enum logic [1:0] {SRC_IF, SRC_DM, SRC_LD} src_e;
  typedef struct packed {
    src_e          src;
    logic [DW-1:0] data;
  } resp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  mips32_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mips32_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int    n_checks = 0;
  int    n_errors = 0;
  resp_t exp_q[$];

  // Behavioural single-port synchronous memory.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic take(input src_e src, input string name);
    resp_t r;
    if (exp_q.size() == 0) begin
      check({name, " unexpected"}, 32'd1, 32'd0);
    end else begin
      r = exp_q.pop_front();
      check({name, " source"}, 32'(src), 32'(r.src));
      check({name, " rdata"}, bus.rdata, r.data);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (bus.if_rvalid) take(SRC_IF, "if_rvalid");
      if (bus.dm_rvalid) take(SRC_DM, "dm_rvalid");
      if (bus.ld_rvalid) take(SRC_LD, "ld_rvalid");
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic exp_gnt(input string tag, input logic i, input logic d, input logic l);
    check({tag, " if_gnt"}, 32'(bus.if_gnt), 32'(i));
    check({tag, " dm_gnt"}, 32'(bus.dm_gnt), 32'(d));
    check({tag, " ld_gnt"}, 32'(bus.ld_gnt), 32'(l));
  endtask

  task automatic push(input src_e src, input logic [DW-1:0] data);
    exp_q.push_back('{src: src, data: data});
  endtask

  initial begin
    bus.if_req   = 1'b1; bus.if_addr  = '0;
    bus.dm_req   = 1'b1; bus.dm_we    = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus.ld_req   = 1'b1; bus.ld_we    = 1'b1; bus.ld_addr = 10'd0; bus.ld_wdata = 32'h04010005;

    // Reset held with every requester active.
    repeat (2) cyc();
    settle();
    exp_gnt("reset", 1'b0, 1'b0, 1'b0);
    check("reset mem_en", 32'(bus.mem_en), 32'd0);
    check("reset mem_we", 32'(bus.mem_we), 32'd0);
    check("reset rvalid", 32'({bus.if_rvalid, bus.dm_rvalid, bus.ld_rvalid}), 32'd0);

    // Release: loader wins first and writes @0.
    cyc(); reset = 1'b0; settle();
    exp_gnt("release", 1'b0, 1'b0, 1'b1);
    check("release mem_we", 32'(bus.mem_we), 32'd1);
    check("release mem_wdata", bus.mem_wdata, 32'h04010005);

    cyc(); bus.if_req = 1'b0; bus.dm_req = 1'b0;
    bus.ld_addr = 10'd3; bus.ld_wdata = 32'hFC000000; settle();
    exp_gnt("ld wr3", 1'b0, 1'b0, 1'b1);
    check("ld wr3 mem_addr", 32'(bus.mem_addr), 32'd3);

    cyc(); bus.ld_we = 1'b0; bus.ld_addr = 10'd0; settle();
    exp_gnt("ld rd0", 1'b0, 1'b0, 1'b1);
    check("ld rd0 mem_we", 32'(bus.mem_we), 32'd0);
    push(SRC_LD, 32'h04010005);

    // DM store beats IF; IF follows; DM load returns the stored word.
    cyc(); bus.ld_req = 1'b0;
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 10'd120; bus.dm_wdata = 32'd5;
    bus.if_req = 1'b1; bus.if_addr = 10'd3; settle();
    exp_gnt("dm sw", 1'b0, 1'b1, 1'b0);
    check("dm sw if_stall", 32'(bus.if_stall), 32'd1);

    cyc(); bus.dm_req = 1'b0; settle();
    exp_gnt("if after sw", 1'b1, 1'b0, 1'b0);
    check("if after sw if_stall", 32'(bus.if_stall), 32'd0);
    check("if after sw mem_we", 32'(bus.mem_we), 32'd0);
    push(SRC_IF, 32'hFC000000);

    cyc(); bus.if_req = 1'b0; bus.dm_req = 1'b1; bus.dm_we = 1'b0; settle();
    exp_gnt("dm lw", 1'b0, 1'b1, 1'b0);
    push(SRC_DM, 32'd5);

    cyc(); bus.dm_req = 1'b0;

    // Starvation: DM holds a store stream, IF wins only on its 5th cycle.
    cyc(); bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 10'd200; bus.dm_wdata = 32'hAA;
    bus.if_req = 1'b1; bus.if_addr = 10'd0; settle();
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) begin cyc(); settle(); end
      exp_gnt($sformatf("starve %0d", k), k == 5, k != 5, 1'b0);
      check($sformatf("starve %0d if_stall", k), 32'(bus.if_stall), 32'(k != 5));
      if (k == 5) push(SRC_IF, 32'h04010005);
    end
    cyc(); bus.dm_req = 1'b0; bus.if_req = 1'b0;

    // Same-address writes from LD and DM: LD first, DM later, DM's value remains.
    cyc(); bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 10'd50; bus.ld_wdata = 32'hA5A5A5A5;
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 10'd50; bus.dm_wdata = 32'h5A5A5A5A; settle();
    exp_gnt("wr conflict", 1'b0, 1'b0, 1'b1);
    cyc(); bus.ld_req = 1'b0; settle();
    exp_gnt("dm late wr", 1'b0, 1'b1, 1'b0);
    cyc(); bus.dm_req = 1'b0; bus.ld_req = 1'b1; bus.ld_we = 1'b0; settle();
    exp_gnt("ld rd50", 1'b0, 1'b0, 1'b1);
    push(SRC_LD, 32'h5A5A5A5A);

    // Preload @1/@2, then back-to-back IF reads @0,@1,@2.
    cyc(); bus.ld_we = 1'b1; bus.ld_addr = 10'd1; bus.ld_wdata = 32'h11111111; settle();
    exp_gnt("ld wr1", 1'b0, 1'b0, 1'b1);
    cyc(); bus.ld_addr = 10'd2; bus.ld_wdata = 32'h22222222; settle();
    exp_gnt("ld wr2", 1'b0, 1'b0, 1'b1);
    cyc(); bus.ld_req = 1'b0; bus.if_req = 1'b1; bus.if_addr = 10'd0; settle();
    exp_gnt("if rd0", 1'b1, 1'b0, 1'b0);
    push(SRC_IF, 32'h04010005);
    cyc(); bus.if_addr = 10'd1; settle();
    check("b2b if_rvalid 1", 32'(bus.if_rvalid), 32'd1);
    push(SRC_IF, 32'h11111111);
    cyc(); bus.if_addr = 10'd2; settle();
    check("b2b if_rvalid 2", 32'(bus.if_rvalid), 32'd1);
    push(SRC_IF, 32'h22222222);
    cyc(); bus.if_req = 1'b0; settle();
    check("b2b if_rvalid 3", 32'(bus.if_rvalid), 32'd1);

    // Reset right after a DM read grant cancels the response and blocks writes.
    cyc(); bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 10'd120; settle();
    exp_gnt("dm rd pre-reset", 1'b0, 1'b1, 1'b0);
    cyc(); reset = 1'b1; bus.dm_we = 1'b1; settle();
    check("mid-reset dm_rvalid", 32'(bus.dm_rvalid), 32'd0);
    check("mid-reset mem_we", 32'(bus.mem_we), 32'd0);
    check("mid-reset mem_en", 32'(bus.mem_en), 32'd0);
    cyc(); reset = 1'b0; bus.dm_req = 1'b0;
    repeat (3) cyc();

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
